// File: rtl/system_xem3001v2_core.sv
// Host pipe-in/pipe-out loopback FIFO for the XEM3001v2 board, with status on the LEDs.
// Define SYSTEM_XEM3001V2_FWFT_EN for first-word-fall-through reads (default: registered read).
module system_xem3001v2_core #(
  parameter int MEM_ADDR_WIDTH = 4,
  parameter int MEM_DATA_WIDTH = 16
) (
  input  logic                      ti_clk,
  input  logic                      a_rst_hard_n,
  input  logic                      ti_rst_soft,
  input  logic                      ti_data_in_en,
  input  logic [MEM_DATA_WIDTH-1:0] ti_data_in,
  input  logic                      ti_data_out_en,
  output logic [MEM_DATA_WIDTH-1:0] ti_data_out,
  output logic [7:0]                a_led
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [MEM_ADDR_WIDTH:0] FULL_COUNT = (MEM_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [7:0] LED_RESET = 8'b0010_0000;

  logic [1:0]                rst_sync;
  logic                      rst_n;
  logic [MEM_DATA_WIDTH-1:0] mem [DEPTH];
  logic [MEM_ADDR_WIDTH:0]   wr_ptr;
  logic [MEM_ADDR_WIDTH:0]   rd_ptr;
  logic [MEM_ADDR_WIDTH:0]   count;
  logic                      err;
  logic                      full;
  logic                      empty;
  logic                      do_read;
  logic                      do_write;
  logic                      overflow;
  logic                      underflow;

  // Hard reset asserts immediately but releases only after two ti_clk edges.
  always_ff @(posedge ti_clk or negedge a_rst_hard_n) begin
    if (!a_rst_hard_n) rst_sync <= 2'b00;
    else               rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign do_read   = ti_data_out_en && !empty;
  assign do_write  = ti_data_in_en && (!full || do_read);
  assign overflow  = ti_data_in_en && full && !ti_data_out_en;
  assign underflow = ti_data_out_en && empty;

  always_ff @(posedge ti_clk) begin
    if (rst_n && !ti_rst_soft && do_write)
      mem[wr_ptr[MEM_ADDR_WIDTH-1:0]] <= ti_data_in;
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      a_led  <= LED_RESET;
    end else if (ti_rst_soft) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      a_led  <= LED_RESET;
    end else begin
      if (do_write)
        wr_ptr <= {1'b0, wr_ptr[MEM_ADDR_WIDTH-1:0] + 1'b1};
      if (do_read)
        rd_ptr <= {1'b0, rd_ptr[MEM_ADDR_WIDTH-1:0] + 1'b1};
      if (do_write && !do_read)
        count <= count + 1'b1;
      else if (do_read && !do_write)
        count <= count - 1'b1;
      if (overflow || underflow)
        err <= 1'b1;
      a_led <= {err, full, empty, 5'(count)};
    end
  end

`ifdef SYSTEM_XEM3001V2_FWFT_EN
  assign ti_data_out = empty ? '0 : mem[rd_ptr[MEM_ADDR_WIDTH-1:0]];
`else
  logic [MEM_DATA_WIDTH-1:0] data_q;

  // Underflowing reads leave the last word on the pipe.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n)           data_q <= '0;
    else if (ti_rst_soft) data_q <= '0;
    else if (do_read)     data_q <= mem[rd_ptr[MEM_ADDR_WIDTH-1:0]];
  end

  assign ti_data_out = data_q;
`endif

endmodule

// File: tb/tb_system_xem3001v2_core.sv
// Directed self-checking bench for system_xem3001v2_core in its default registered-read build.
module tb_system_xem3001v2_core;

  logic        ti_clk = 1'b0;
  logic        a_rst_hard_n = 1'b1;
  logic        ti_rst_soft = 1'b0;
  logic        ti_data_in_en = 1'b0;
  logic [15:0] ti_data_in = '0;
  logic        ti_data_out_en = 1'b0;
  logic [15:0] ti_data_out;
  logic [7:0]  a_led;

  int vectors = 0;
  int miscompares = 0;

  system_xem3001v2_core #(.MEM_ADDR_WIDTH(4), .MEM_DATA_WIDTH(16)) dut (
    .ti_clk(ti_clk),
    .a_rst_hard_n(a_rst_hard_n),
    .ti_rst_soft(ti_rst_soft),
    .ti_data_in_en(ti_data_in_en),
    .ti_data_in(ti_data_in),
    .ti_data_out_en(ti_data_out_en),
    .ti_data_out(ti_data_out),
    .a_led(a_led)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic tick();
    @(posedge ti_clk);
    #1;
  endtask

  task automatic hard_reset();
    a_rst_hard_n = 1'b0;
    repeat (5) tick();
    a_rst_hard_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    tick();
    a_rst_hard_n = 1'b0;
    #1;
    vectors++;
    if (a_led !== 8'h20) begin
      miscompares++;
      $display("[TB] FAIL reset_assert_led: got %h want %h", a_led, 8'h20);
    end
    repeat (5) tick();
    a_rst_hard_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (a_led !== 8'h20) begin
      miscompares++;
      $display("[TB] FAIL reset_release_led: got %h want %h", a_led, 8'h20);
    end
    vectors++;
    if (ti_data_out !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_data: got %h want %h", ti_data_out, 16'h0);
    end
    for (int i = 0; i < 3; i++) begin
      ti_data_in_en = 1'b1;
      ti_data_in = 16'(i + 7);
      tick();
    end
    ti_data_in_en = 1'b0;
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'h03) begin
      miscompares++;
      $display("[TB] FAIL prereset_count: got %h want %h", a_led, 8'h03);
    end
    a_rst_hard_n = 1'b0;
    #1;
    vectors++;
    if (a_led !== 8'h20) begin
      miscompares++;
      $display("[TB] FAIL midstream_hard_reset: got %h want %h", a_led, 8'h20);
    end
    repeat (4) tick();
    a_rst_hard_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_soft_reset();
    ti_data_out_en = 1'b1;
    tick();
    ti_data_out_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ti_data_in_en = 1'b1;
      ti_data_in = 16'(i + 1);
      tick();
    end
    ti_data_in_en = 1'b0;
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'h83) begin
      miscompares++;
      $display("[TB] FAIL soft_pre_led: got %h want %h", a_led, 8'h83);
    end
    ti_rst_soft = 1'b1;
    repeat (5) tick();
    ti_rst_soft = 1'b0;
    tick();
    vectors++;
    if (a_led !== 8'h20) begin
      miscompares++;
      $display("[TB] FAIL soft_reset_led: got %h want %h", a_led, 8'h20);
    end
    vectors++;
    if (ti_data_out !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL soft_reset_data: got %h want %h", ti_data_out, 16'h0);
    end
  endtask

  task automatic test_pipe_in();
    for (int i = 1; i <= 10; i++) begin
      ti_data_in_en = 1'b1;
      ti_data_in = 16'(i);
      tick();
    end
    ti_data_in_en = 1'b0;
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'h0A) begin
      miscompares++;
      $display("[TB] FAIL pipe_in_led: got %h want %h", a_led, 8'h0A);
    end
  endtask

  task automatic test_pipe_out();
    logic [15:0] expected;
    ti_data_out_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      expected = (k <= 10) ? 16'(k) : 16'd10;
      vectors++;
      if (ti_data_out !== expected) begin
        miscompares++;
        $display("[TB] FAIL pipe_out_word%0d: got %0d want %0d", k, ti_data_out, expected);
      end
    end
    ti_data_out_en = 1'b0;
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'hA0) begin
      miscompares++;
      $display("[TB] FAIL pipe_out_final_led: got %h want %h", a_led, 8'hA0);
    end
  endtask

  task automatic test_full_wrap();
    ti_rst_soft = 1'b1;
    tick();
    ti_rst_soft = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ti_data_in_en = 1'b1;
      ti_data_in = 16'(100 + i);
      tick();
    end
    ti_data_in_en = 1'b0;
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'hD0) begin
      miscompares++;
      $display("[TB] FAIL full_led: got %h want %h", a_led, 8'hD0);
    end
    ti_data_out_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      vectors++;
      if (ti_data_out !== 16'(100 + k)) begin
        miscompares++;
        $display("[TB] FAIL full_drain%0d: got %0d want %0d", k, ti_data_out, 100 + k);
      end
    end
    ti_data_out_en = 1'b0;
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'hA0) begin
      miscompares++;
      $display("[TB] FAIL drained_led: got %h want %h", a_led, 8'hA0);
    end
    // Park the pointers at 12 so the next burst straddles the wrap.
    for (int i = 0; i < 12; i++) begin
      ti_data_in_en = 1'b1;
      ti_data_in = 16'(200 + i);
      tick();
    end
    ti_data_in_en = 1'b0;
    ti_data_out_en = 1'b1;
    repeat (12) tick();
    ti_data_out_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ti_data_in_en = 1'b1;
      ti_data_in = 16'(300 + i);
      tick();
    end
    ti_data_in_en = 1'b0;
    ti_data_out_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if (ti_data_out !== 16'(300 + k)) begin
        miscompares++;
        $display("[TB] FAIL wrap_read%0d: got %0d want %0d", k, ti_data_out, 300 + k);
      end
    end
    ti_data_out_en = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    ti_rst_soft = 1'b1;
    tick();
    ti_rst_soft = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ti_data_in_en = 1'b1;
      ti_data_in = 16'(400 + i);
      tick();
    end
    ti_data_in = 16'd416;
    ti_data_out_en = 1'b1;
    tick();
    ti_data_in_en = 1'b0;
    ti_data_out_en = 1'b0;
    vectors++;
    if (ti_data_out !== 16'd400) begin
      miscompares++;
      $display("[TB] FAIL full_rw_data: got %0d want %0d", ti_data_out, 400);
    end
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'h50) begin
      miscompares++;
      $display("[TB] FAIL full_rw_led: got %h want %h", a_led, 8'h50);
    end
    hard_reset();
    ti_data_in_en = 1'b1;
    ti_data_in = 16'd500;
    ti_data_out_en = 1'b1;
    tick();
    ti_data_in_en = 1'b0;
    ti_data_out_en = 1'b0;
    vectors++;
    if (ti_data_out !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL empty_rw_data: got %0d want %0d", ti_data_out, 0);
    end
    repeat (2) tick();
    vectors++;
    if (a_led !== 8'h81) begin
      miscompares++;
      $display("[TB] FAIL empty_rw_led: got %h want %h", a_led, 8'h81);
    end
    ti_data_out_en = 1'b1;
    tick();
    ti_data_out_en = 1'b0;
    vectors++;
    if (ti_data_out !== 16'd500) begin
      miscompares++;
      $display("[TB] FAIL empty_rw_readback: got %0d want %0d", ti_data_out, 500);
    end
  endtask

  initial begin
    test_reset();
    test_soft_reset();
    test_pipe_in();
    test_pipe_out();
    test_full_wrap();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
